adder_serial_nbit: RTL and testbench
====================================

# adder_serial_nbit

Bit-serial N-bit adder that consumes two parallel operands and processes one bit per clock, LSB first. Each bit is summed by a full-adder cell built from two `adder_half_1bit` instances, with the carry held in a flip-flop between bits. It sits downstream of the 1-bit half-adder stage and turns that combinational primitive into a multi-cycle, handshaked arithmetic unit for area-constrained datapaths.

## Interface

Parameters:

- `WIDTH`, default 8: operand and sum width in bits. Legal range is ≥1.

Ports:

- `Clk`, input, 1: sole clock; all state changes on the rising edge.
- `Reset`, input, 1: synchronous, active-high reset.
- `input_start`, input, 1: request to begin an addition. Sampled only when idle or done.
- `input_a`, input, `WIDTH`: operand A. Captured on an accepted start.
- `input_b`, input, `WIDTH`: operand B. Captured on an accepted start.
- `output_busy`, output, 1: high while bits are being processed.
- `output_done`, output, 1: one-cycle pulse; the result has just become valid.
- `output_sum`, output, `WIDTH`: registered sum of the last completed addition.
- `output_carry`, output, 1: registered carry-out of the last completed addition.

## Operation

- **State machine** has three states: IDLE, BUSY, DONE.
  - IDLE: `input_start`=1 → load operand shift registers from `input_a`/`input_b`, clear carry FF, clear bit counter, go to BUSY. Otherwise stay in IDLE.
  - BUSY: every cycle, add `a_sh[0]`, `b_sh[0]` and the carry FF.
    - Sum bit shifts into the MSB of the internal sum shift register.
    - Carry FF takes the full-adder carry.
    - Operands shift right by one.
    - Counter increments.
    - When the counter reaches `WIDTH`-1: copy the internal sum (including this bit) to `output_sum`, copy the final carry to `output_carry`, go to DONE.
  - DONE: `output_done`=1. `input_start`=1 → accept as in IDLE (back-to-back) and go to BUSY. Otherwise go to IDLE.
- **Start is ignored in BUSY.** Operands are not re-sampled and the operation completes undisturbed.
- **Operands** need to be valid only in the cycle start is accepted. Later changes have no effect.
- **Arithmetic:** {`output_carry`, `output_sum`} = `input_a` + `input_b`, unsigned, (`WIDTH`+1) bits. No overflow beyond the carry.
- **Result hold:** `output_sum` and `output_carry` hold the previous result through IDLE and BUSY. They change only on the transition into DONE.
- **Full-adder cell:** two `adder_half_1bit` instances plus an OR on the two carries. No behavioural `+` is used on the bit path.
- **Counter width:** $clog2(`WIDTH`), minimum 1 bit.
- **`WIDTH`=1:** BUSY lasts exactly one cycle.

## Timing

- **Reset** (sampled high at an edge) forces, after that edge:
  - state = IDLE
  - `output_busy`=0, `output_done`=0
  - `output_sum`=0, `output_carry`=0
  - carry FF, counter and shift registers = 0
- **Reset has priority** over `input_start`.
- **Reset mid-BUSY or in DONE** aborts the operation. The partial result is discarded and no `output_done` pulse occurs.
- **Latency:** start accepted at edge k.
  - `output_busy`=1 from after edge k through edge k+`WIDTH`.
  - State = DONE and the result is valid after edge k+`WIDTH`.
  - `output_done` is high for exactly one cycle, between edges k+`WIDTH` and k+`WIDTH`+1.
- **Throughput:** one result per `WIDTH`+1 cycles with back-to-back starts. With a start in every DONE cycle, `output_busy` deasserts only during the DONE cycles.
- **Output decoding:** `output_busy` = (state==BUSY) and `output_done` = (state==DONE). Both are combinational from state registers only, so no glitch paths come from inputs.
- **Data outputs** (`output_sum`, `output_carry`) are registered, so there is no combinational path from `input_a`/`input_b` to any output.

## Test plan

- **Reset values:** `Reset`=1 for 2 cycles with `input_start`=1 → `output_busy`=0, `output_done`=0, `output_sum`=0x00, `output_carry`=0 throughout. The block is idle after release.
- **Zero operands and pulse timing:** `WIDTH`=8, A=0x00, B=0x00, start pulsed at edge k → `output_busy`=1 for 8 cycles; `output_done`=1 only after edge k+8; sum=0x00, carry=0.
- **Full carry ripple:** A=0xFF, B=0x01 → sum=0x00, carry=1. A=0xA5, B=0x5A → sum=0xFF, carry=0. During the second operation, outputs hold 0x00/1 until its DONE.
- **Ignored start and input independence:** start re-asserted and A/B changed to 0x11/0x22 mid-BUSY of 0x0F+0x01 → the change is ignored; sum=0x10, carry=0, done exactly once.
- **Reset mid-operation:** 0x80+0x80 started, `Reset`=1 at the 4th BUSY cycle → no done pulse; sum=0x00, carry=0. The next start of 0x80+0x80 → sum=0x00, carry=1.
- **`WIDTH`=1 exhaustive and back-to-back:** `WIDTH`=1, all four (a,b) pairs with a start in each DONE cycle → {carry,sum} = 00, 01, 01, 10 matching the half-adder truth table; done pulses every 2 cycles.

Source files
------------

// File: rtl/adder_serial_nbit.sv
// Bit-serial unsigned adder: one full-adder cell (two half adders) processes one operand bit per
// clock, LSB first, with the carry held in a flop between bits.

module adder_half_1bit (
    input  logic input_a,
    input  logic input_b,
    output logic output_sum,
    output logic output_carry
);

    always_comb begin
        output_sum   = input_a ^ input_b;
        output_carry = input_a & input_b;
    end

endmodule

module adder_serial_nbit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             input_start,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic             output_busy,
    output logic             output_done,
    output logic [WIDTH-1:0] output_sum,
    output logic             output_carry
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic             ha0_sum, ha0_carry;
    logic             fa_sum, ha1_carry;
    logic             fa_carry;
    logic [WIDTH-1:0] sum_sh_shift;

    adder_half_1bit u_ha0 (
        .input_a      (a_sh_q[0]),
        .input_b      (b_sh_q[0]),
        .output_sum   (ha0_sum),
        .output_carry (ha0_carry)
    );

    adder_half_1bit u_ha1 (
        .input_a      (ha0_sum),
        .input_b      (carry_q),
        .output_sum   (fa_sum),
        .output_carry (ha1_carry)
    );

    assign fa_carry = ha0_carry | ha1_carry;

    // New sum bit enters at the MSB so after WIDTH shifts the LSB lands in bit 0.
    if (WIDTH == 1) begin : g_w1
        assign sum_sh_shift = fa_sum;
    end else begin : g_wn
        assign sum_sh_shift = {fa_sum, sum_sh_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (input_start) begin
                    a_sh_d   = input_a;
                    b_sh_d   = input_b;
                    sum_sh_d = '0;
                    cnt_d    = '0;
                    carry_d  = 1'b0;
                    state_d  = StBusy;
                end else begin
                    state_d = StIdle;
                end
            end
            StBusy: begin
                sum_sh_d = sum_sh_shift;
                carry_d  = fa_carry;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    sum_d   = sum_sh_shift;
                    cout_d  = fa_carry;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
        end
    end

    assign output_busy  = (state_q == StBusy);
    assign output_done  = (state_q == StDone);
    assign output_sum   = sum_q;
    assign output_carry = cout_q;

endmodule

// File: tb/tb_adder_serial_nbit.sv
// Bench for adder_serial_nbit: a WIDTH=8 and a WIDTH=1 instance checked every cycle against a
// transaction-level model, plus directed literal checks.

module tb_adder_serial_nbit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start [2];
    logic [7:0] in_a  [2];
    logic [7:0] in_b  [2];

    logic       o_busy  [2];
    logic       o_done  [2];
    logic [7:0] o_sum   [2];
    logic       o_carry [2];

    logic       busy8, done8, carry8, busy1, done1, carry1, sum1;
    logic [7:0] sum8;

    int checks = 0;
    int errors = 0;
    int done_cnt8 = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    adder_serial_nbit #(.WIDTH(8)) dut8 (
        .Clk          (clk),
        .Reset        (rst),
        .input_start  (start[0]),
        .input_a      (in_a[0]),
        .input_b      (in_b[0]),
        .output_busy  (busy8),
        .output_done  (done8),
        .output_sum   (sum8),
        .output_carry (carry8)
    );

    adder_serial_nbit #(.WIDTH(1)) dut1 (
        .Clk          (clk),
        .Reset        (rst),
        .input_start  (start[1]),
        .input_a      (in_a[1][0]),
        .input_b      (in_b[1][0]),
        .output_busy  (busy1),
        .output_done  (done1),
        .output_sum   (sum1),
        .output_carry (carry1)
    );

    assign o_busy[0]  = busy8;
    assign o_done[0]  = done8;
    assign o_sum[0]   = sum8;
    assign o_carry[0] = carry8;
    assign o_busy[1]  = busy1;
    assign o_done[1]  = done1;
    assign o_sum[1]   = {7'b0, sum1};
    assign o_carry[1] = carry1;

    // Transaction model: an accepted start schedules a+b to appear WIDTH cycles later.
    int         m_left  [2];
    logic       m_done  [2];
    logic [7:0] m_sum   [2];
    logic       m_carry [2];
    logic [8:0] m_pend  [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int         w;
            logic [8:0] mask;
            w    = (i == 0) ? 8 : 1;
            mask = (9'd1 << w) - 9'd1;
            if (rst) begin
                m_left[i]  <= 0;
                m_done[i]  <= 1'b0;
                m_sum[i]   <= 8'h00;
                m_carry[i] <= 1'b0;
            end else if (m_left[i] > 0) begin
                m_left[i] <= m_left[i] - 1;
                m_done[i] <= (m_left[i] == 1);
                if (m_left[i] == 1) begin
                    m_sum[i]   <= m_pend[i][7:0] & mask[7:0];
                    m_carry[i] <= m_pend[i][w];
                end
            end else begin
                m_done[i] <= 1'b0;
                if (start[i]) begin
                    m_pend[i] <= ({1'b0, in_a[i]} & mask) + ({1'b0, in_b[i]} & mask);
                    m_left[i] <= w;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("busy[%0d]", i), {8'b0, o_busy[i]}, {8'b0, m_left[i] > 0});
                chk($sformatf("done[%0d]", i), {8'b0, o_done[i]}, {8'b0, m_done[i]});
                chk($sformatf("result[%0d]", i), {o_carry[i], o_sum[i]}, {m_carry[i], m_sum[i]});
            end
        end
    end

    always @(negedge clk) if (done8) done_cnt8++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start8(input logic [7:0] a, input logic [7:0] b);
        in_a[0]  = a;
        in_b[0]  = b;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
    endtask

    // Waits for done on the WIDTH=8 unit, checking busy length and the literal result.
    task automatic finish8(input string name, input int exp_busy, input logic [7:0] es,
                           input logic ec);
        int  busy_cnt = 0;
        bit  seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (done8) seen = 1'b1;
            else if (busy8) busy_cnt++;
        end
        chk({name, " done seen"}, {8'b0, seen}, 9'd1);
        chk({name, " busy cycles"}, 9'(busy_cnt), 9'(exp_busy));
        chk({name, " result"}, {carry8, sum8}, {ec, es});
        tick();
    endtask

    initial begin
        logic [1:0] exp1 [4];
        int         dc;
        exp1[0] = 2'b00; exp1[1] = 2'b01; exp1[2] = 2'b01; exp1[3] = 2'b10;
        start[0] = 1'b1; start[1] = 1'b1;
        in_a[0] = 8'h5A; in_b[0] = 8'hC3; in_a[1] = 8'h01; in_b[1] = 8'h01;

        // Reset held with start asserted.
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        chk("reset busy8/done8", {7'b0, busy8, done8}, 9'd0);
        chk("reset result8", {carry8, sum8}, 9'h000);
        tick();
        start[0] = 1'b0; start[1] = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        chk("idle after reset", {7'b0, busy8, done8}, 9'd0);

        start8(8'h00, 8'h00);
        finish8("0+0", 8, 8'h00, 1'b0);

        start8(8'hFF, 8'h01);
        finish8("FF+01", 8, 8'h00, 1'b1);

        start8(8'hA5, 8'h5A);
        chk("A5+5A hold prev", {carry8, sum8}, 9'h100);
        finish8("A5+5A", 8, 8'hFF, 1'b0);

        // Start and operand changes during BUSY must be ignored.
        dc = done_cnt8;
        start8(8'h0F, 8'h01);
        start[0] = 1'b1; in_a[0] = 8'h11; in_b[0] = 8'h22;
        tick(); tick(); tick();
        start[0] = 1'b0;
        finish8("0F+01 ignored start", 5, 8'h10, 1'b0);
        tick(); tick();
        chk("single done pulse", 9'(done_cnt8 - dc), 9'd1);

        // Reset during the 4th BUSY cycle aborts the add.
        dc = done_cnt8;
        start8(8'h80, 8'h80);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (12) tick();
        chk("no done after abort", 9'(done_cnt8 - dc), 9'd0);
        chk("abort result", {carry8, sum8}, 9'h000);
        start8(8'h80, 8'h80);
        finish8("80+80", 8, 8'h00, 1'b1);

        // WIDTH=1: all pairs back-to-back, start held through every DONE cycle.
        start[1] = 1'b1;
        for (int p = 0; p < 4; p++) begin
            in_a[1] = {7'b0, p[1]};
            in_b[1] = {7'b0, p[0]};
            tick();
            chk($sformatf("w1 busy pair %0d", p), {8'b0, busy1}, 9'd1);
            tick();
            chk($sformatf("w1 done pair %0d", p), {8'b0, done1}, 9'd1);
            chk($sformatf("w1 result pair %0d", p), {7'b0, carry1, sum1}, {7'b0, exp1[p]});
        end
        start[1] = 1'b0;
        tick();
        tick();
        chk("w1 idle", {7'b0, busy1, done1}, 9'd0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
